// File: rtl/mp_alu_sequencer.sv
// Multi-precision add/sub/compare sequencer: walks N-byte operands through the
// external 8-bit ALU, chaining carry/borrow and writing results back to data memory.
module mp_alu_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  output logic              busy,
  output logic              done,
  output logic              z_flag,
  output logic              c_flag,
  output logic              n_flag,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              alu_optype,
  output logic [3:0]        alu_op,
  output logic [7:0]        alu_acc,
  output logic [7:0]        alu_reg,
  input  logic [7:0]        alu_out,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_FIX, S_WR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
  logic [7:0]        a_byte_q, a_byte_d, res_q, res_d;
  logic              carry_q, carry_d, c1_q, c1_d, nz_acc_q, nz_acc_d;
  logic              z_q, z_d, c_q, c_d, n_q, n_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              legal_op, is_cmp;

  assign legal_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  assign is_cmp   = (op_q == OP_CMP);
  assign busy     = busy_q;
  assign done     = done_q;
  assign z_flag   = z_q;
  assign c_flag   = c_q;
  assign n_flag   = n_q;

  // Next-state, datapath capture and memory/ALU port drive
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    idx_d      = idx_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    d_base_d   = d_base_q;
    a_byte_d   = a_byte_q;
    res_d      = res_q;
    carry_d    = carry_q;
    c1_d       = c1_q;
    nz_acc_d   = nz_acc_q;
    z_d        = z_q;
    c_d        = c_q;
    n_d        = n_q;
    mem_raddr  = '0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    alu_optype = 1'b0;
    alu_op     = '0;
    alu_acc    = '0;
    alu_reg    = '0;

    case (state_q)
      S_IDLE: begin
        if (start && legal_op) begin
          if (len == '0) begin
            state_d = S_DONE;
            z_d     = 1'b1;
            c_d     = 1'b0;
            n_d     = 1'b0;
          end else begin
            state_d  = S_RD_A;
            op_d     = op;
            len_d    = len;
            a_base_d = a_base;
            b_base_d = b_base;
            d_base_d = d_base;
            idx_d    = (op == OP_CMP) ? len - LEN_W'(1) : '0;
            carry_d  = 1'b0;
            nz_acc_d = 1'b0;
          end
        end
      end
      S_RD_A: begin
        mem_raddr = a_base_q + ADDR_W'(idx_q);
        state_d   = S_RD_B;
      end
      S_RD_B: begin
        mem_raddr = b_base_q + ADDR_W'(idx_q);
        a_byte_d  = mem_rdata;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        alu_op  = op_q;
        alu_acc = a_byte_q;
        alu_reg = mem_rdata;
        if (is_cmp) begin
          // Compare walks MSB first, so the first unequal byte decides
          if (!alu_z) begin
            state_d = S_DONE;
            z_d     = 1'b0;
            c_d     = 1'b0;
            n_d     = alu_n;
          end else if (idx_q == '0) begin
            state_d = S_DONE;
            z_d     = 1'b1;
            c_d     = 1'b0;
            n_d     = 1'b0;
          end else begin
            idx_d   = idx_q - LEN_W'(1);
            state_d = S_RD_A;
          end
        end else begin
          res_d = alu_out;
          c1_d  = alu_c;
          if (carry_q) begin
            state_d = S_FIX;
          end else begin
            carry_d = alu_c;
            state_d = S_WR;
          end
        end
      end
      S_FIX: begin
        // Fold the incoming carry/borrow in as a second +/-1 pass
        alu_op  = op_q;
        alu_acc = res_q;
        alu_reg = 8'd1;
        res_d   = alu_out;
        carry_d = c1_q | alu_c;
        state_d = S_WR;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_waddr = d_base_q + ADDR_W'(idx_q);
        mem_wdata = res_q;
        nz_acc_d  = nz_acc_q | (res_q != 8'd0);
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = S_DONE;
          z_d     = ~(nz_acc_q | (res_q != 8'd0));
          c_d     = carry_q;
          n_d     = res_q[7];
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      a_byte_q <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      nz_acc_q <= 1'b0;
      z_q      <= 1'b1;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      d_base_q <= d_base_d;
      a_byte_q <= a_byte_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      nz_acc_q <= nz_acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
